// File: rtl/c1_csum_check.sv
// c1_csum_check: receive-side one's-complement checksum checker.
// Consumes a packet of W-bit words (the last one is the sender's checksum)
// and folds every word into an end-around-carry accumulator. A packet
// passes when the final sum is all-ones (negative zero) and the packet did
// not exceed MAX_WORDS. One packet is in flight at a time.
//
// Handshake: a beat transfers on a rising clk edge when in_valid and
// in_ready are both high; in_data/in_last are ignored on any other edge.
// The source must hold in_valid/in_data/in_last until the beat transfers.
// in_ready is registered: low in reset, low for the single DONE cycle,
// high otherwise.
//
// The FSM state is the enum signal 'state' (IDLE/ACC/DONE), kept as a
// named signal so checkers can bind to it directly.
module c1_csum_check #(
    parameter int W         = 8,
    parameter int CNT_W     = 8,
    parameter int MAX_WORDS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             done,
    output logic             pass,
    output logic             err_len,
    output logic [W-1:0]     sum_out,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [W-1:0]     ALL_ONE = {W{1'b1}};

    state_t           state;
    logic [W-1:0]     acc;
    logic             len_over;

    logic             accept;
    logic [W:0]       sum_wide;
    logic [W-1:0]     acc_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             over_next;

    // Datapath: end-around-carry add of the incoming word, counter step
    // and length-overflow lookahead for the word being accepted.
    always_comb begin
        accept    = in_valid & in_ready;
        sum_wide  = {1'b0, acc} + {1'b0, in_data};
        // Folding the single carry back in cannot overflow again: the
        // largest W-bit sum-with-carry is 2^(W+1)-2, which folds to 2^W-1.
        acc_next  = sum_wide[W-1:0] + {{(W-1){1'b0}}, sum_wide[W]};
        cnt_inc   = (word_cnt == CNT_SAT) ? word_cnt : word_cnt + CNT_W'(1);
        // word_cnt still holds the count before this word, so reaching
        // MAX_CNT means the accepted word is one past the limit.
        over_next = len_over | (word_cnt >= MAX_CNT);
    end

    // Packet FSM with registered handshake, verdict and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            len_over <= 1'b0;
            word_cnt <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_len  <= 1'b0;
            sum_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    done     <= 1'b0;
                    if (accept) begin
                        acc      <= in_data;
                        word_cnt <= CNT_W'(1);
                        len_over <= 1'b0;
                        err_len  <= 1'b0;
                        if (in_last) begin
                            // Single-word packet: the word itself is the sum.
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            sum_out  <= in_data;
                            pass     <= (in_data == ALL_ONE);
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    in_ready <= 1'b1;
                    done     <= 1'b0;
                    if (accept) begin
                        acc      <= acc_next;
                        word_cnt <= cnt_inc;
                        len_over <= over_next;
                        if (in_last) begin
                            // Verdict is loaded here so it is visible
                            // during the DONE cycle itself.
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            sum_out  <= acc_next;
                            pass     <= (acc_next == ALL_ONE) & ~over_next;
                            err_len  <= over_next;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    done     <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c1_csum_check.sv
// tb_c1_csum_check: directed bench for c1_csum_check (W=8, MAX_WORDS=3).
// Expected verdicts are computed from each packet when it is driven and
// queued; a negedge monitor pops and compares them when done pulses, and
// also tracks in_ready and done timing against a cycle-level model.
module tb_c1_csum_check;

    localparam int W         = 8;
    localparam int CNT_W     = 8;
    localparam int MAX_WORDS = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             done;
    logic             pass;
    logic             err_len;
    logic [W-1:0]     sum_out;
    logic [CNT_W-1:0] word_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // {pass, err_len, sum[7:0], cnt[7:0]}
    logic [17:0] exp_q[$];

    logic beat_last;
    logic ready_exp;

    c1_csum_check #(
        .W        (W),
        .CNT_W    (CNT_W),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .in_last (in_last),
        .done    (done),
        .pass    (pass),
        .err_len (err_len),
        .sum_out (sum_out),
        .word_cnt(word_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum folded mod (2^8 - 1) style.
    function automatic logic [17:0] model(input int n, input logic [7:0] w[4]);
        int s;
        logic p;
        logic e;
        s = 0;
        for (int i = 0; i < n; i++) s += int'(w[i]);
        while (s > 255) s = (s & 255) + (s >> 8);
        e = (n > MAX_WORDS);
        p = (s == 255) && !e;
        return {p, e, 8'(s), 8'(n)};
    endfunction

    // Cycle model: done follows an accepted last beat by one cycle, and
    // in_ready is low exactly in that cycle (and in reset).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_last <= 1'b0;
            ready_exp <= 1'b0;
        end else begin
            beat_last <= in_valid && in_ready && in_last;
            ready_exp <= !(in_valid && in_ready && in_last);
        end
    end

    // Scoreboard / monitor
    always @(negedge clk) begin
        logic [17:0] e;
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(ready_exp));
            if (done || beat_last) check("done_timing", 32'(done), 32'(beat_last));
            if (done) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pass",     32'(pass),     32'(e[17]));
                    check("err_len",  32'(err_len),  32'(e[16]));
                    check("sum_out",  32'(sum_out),  32'(e[15:8]));
                    check("word_cnt", 32'(word_cnt), 32'(e[7:0]));
                end
            end
        end
    end

    // Drivers
    task automatic send_word(input logic [7:0] d, input logic l);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("accept_wait", 32'(budget < 20), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_pkt(input int n, input logic [7:0] w[4]);
        exp_q.push_back(model(n, w));
        for (int i = 0; i < n; i++) send_word(w[i], (i == n - 1));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_pass"},     32'(pass),     32'd0);
        check({tag, "_err_len"},  32'(err_len),  32'd0);
        check({tag, "_sum_out"},  32'(sum_out),  32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_ready_high", 32'(in_ready), 32'd1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        logic [7:0] pk[4];
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        release_reset();

        // Basic packet
        pk = '{8'h12, 8'h34, 8'hB9, 8'h00};
        send_pkt(3, pk);
        idle(2);

        // End-around carry, good and corrupted
        pk = '{8'hF0, 8'h20, 8'hEE, 8'h00};
        send_pkt(3, pk);
        idle(1);
        pk = '{8'hF0, 8'h20, 8'hED, 8'h00};
        send_pkt(3, pk);
        idle(1);

        // Single-word packets
        pk = '{8'hFF, 8'h00, 8'h00, 8'h00};
        send_pkt(1, pk);
        idle(1);
        pk = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(1, pk);
        idle(1);

        // Back-to-back with in_valid held high across the DONE cycle
        pk = '{8'h12, 8'h34, 8'hB9, 8'h00};
        send_pkt(3, pk);
        pk = '{8'hF0, 8'h20, 8'hED, 8'h00};
        send_pkt(3, pk);
        pk = '{8'hFF, 8'h00, 8'h00, 8'h00};
        send_pkt(1, pk);
        idle(2);

        // Over-length packet summing to all-ones, then recovery
        pk = '{8'h10, 8'h20, 8'h30, 8'h9F};
        send_pkt(4, pk);
        idle(1);
        pk = '{8'hFF, 8'h00, 8'h00, 8'h00};
        send_pkt(1, pk);
        idle(1);

        // Reset in the middle of a packet: partial packet discarded
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        release_reset();
        pk = '{8'h12, 8'h34, 8'hB9, 8'h00};
        send_pkt(3, pk);
        idle(4);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
